apple_bus_event_fifo: RTL and testbench

- Sits directly downstream of the Apple II bus interface stage and consumes its sampled address, data and rw_n plus the data_in_strobe pulse.
- Filters bus cycles against a parameterised address window and buffers matching cycles as events in a FIFO.
- Slower consumers (soft-switch shadows, card register files, debug capture) pop events with a valid/ready handshake.
- Lets consumers that stall for many clk_logic cycles see every qualifying Apple II bus cycle without missing strobes.

---
 rtl/apple_bus_event_fifo.sv | 127 ++++++++++++
 tb/tb_apple_bus_event_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/apple_bus_event_fifo.sv
// Event FIFO for Apple II bus cycles: filters strobed cycles against an address
// window and buffers them for slower consumers behind a registered FWFT head.
module apple_bus_event_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter logic [15:0] ADDR_MASK     = 16'hFFF0,
  parameter logic [15:0] ADDR_MATCH    = 16'hC080,
  parameter bit          CAPTURE_READS = 1'b0
) (
  input  logic                       clk_logic,
  input  logic                       reset,
  input  logic [15:0]                addr_i,
  input  logic [7:0]                 data_i,
  input  logic                       rw_n_i,
  input  logic                       data_in_strobe_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [15:0]                evt_addr_o,
  output logic [7:0]                 evt_data_o,
  output logic                       evt_rw_n_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_count_o,
  input  logic                       overflow_clr_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
  } evt_t;

  localparam evt_t EVT_RESET = '{addr: 16'h0000, data: 8'h00, rw_n: 1'b1};

  evt_t          mem_q [DEPTH];
  evt_t          head_q, head_d, in_evt;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          qual, pop, push, drop, full;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    in_evt     = '{addr: addr_i, data: data_i, rw_n: rw_n_i};
    qual       = data_in_strobe_i && ((addr_i & ADDR_MASK) == ADDR_MATCH)
                 && (!rw_n_i || CAPTURE_READS);
    pop        = valid_q && evt_ready_i;
    full       = (level_q == FULL_LEVEL);
    push       = qual && (!full || pop);
    drop       = qual && full && !pop;

    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    level_d    = level_q + LW'(push) - LW'(pop);
    valid_d    = (level_d != '0);

    // The head register is reloaded only when it is consumed or empty; an
    // entry pushed into an otherwise-empty FIFO bypasses storage.
    head_d     = head_q;
    if (pop || !valid_q) begin
      if (push && ((level_q - LW'(pop)) == '0)) begin
        head_d = in_evt;
      end else if (level_d != '0) begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr_i) begin
      overflow_d = 1'b0;
    end

    drop_cnt_d = drop_cnt_q;
    if (overflow_clr_i) begin
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= EVT_RESET;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk_logic) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= in_evt;
    end
  end

  assign evt_valid_o  = valid_q;
  assign evt_addr_o   = head_q.addr;
  assign evt_data_o   = head_q.data;
  assign evt_rw_n_o   = head_q.rw_n;
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_apple_bus_event_fifo.sv
// Scoreboard bench for apple_bus_event_fifo: a queue model tracks accepted
// events, drops and level; a negedge monitor compares the DUT every cycle.
module tb_apple_bus_event_fifo;

  localparam int DEPTH = 16;

  logic        clk_logic = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr_i = '0;
  logic [7:0]  data_i = '0;
  logic        rw_n_i = 1'b1;
  logic        data_in_strobe_i = 1'b0;
  logic        evt_ready_i = 1'b0;
  logic        overflow_clr_i = 1'b0;
  logic        evt_valid_o;
  logic [15:0] evt_addr_o;
  logic [7:0]  evt_data_o;
  logic        evt_rw_n_o;
  logic [4:0]  level_o;
  logic        overflow_o;
  logic [7:0]  drop_count_o;

  apple_bus_event_fifo #(
    .DEPTH(DEPTH), .ADDR_MASK(16'hFFF0), .ADDR_MATCH(16'hC080), .CAPTURE_READS(1'b0)
  ) dut (
    .clk_logic(clk_logic), .reset(reset), .addr_i(addr_i), .data_i(data_i),
    .rw_n_i(rw_n_i), .data_in_strobe_i(data_in_strobe_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_addr_o(evt_addr_o), .evt_data_o(evt_data_o), .evt_rw_n_o(evt_rw_n_o),
    .level_o(level_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o),
    .overflow_clr_i(overflow_clr_i)
  );

  always #5 clk_logic = ~clk_logic;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model
  logic [24:0] sb[$];
  logic        m_ovf = 1'b0;
  logic [7:0]  m_cnt = 8'h00;
  bit          model_ok = 1'b0;

  function automatic bit qualifies(input logic [15:0] a, input logic rw);
    return ((a & 16'hFFF0) == 16'hC080) && !rw;
  endfunction

  always @(negedge clk_logic) begin
    bit q, pop, drop;
    if (model_ok) begin
      check("level", 32'(level_o), 32'(sb.size()));
      check("valid", 32'(evt_valid_o), 32'(sb.size() != 0));
      check("overflow", 32'(overflow_o), 32'(m_ovf));
      check("drop_count", 32'(drop_count_o), 32'(m_cnt));
      if (sb.size() != 0)
        check("head", 32'({evt_addr_o, evt_data_o, evt_rw_n_o}), 32'(sb[0]));
    end
    if (reset) begin
      sb.delete();
      m_ovf    = 1'b0;
      m_cnt    = 8'h00;
      model_ok = 1'b1;
    end else begin
      q    = data_in_strobe_i && qualifies(addr_i, rw_n_i);
      pop  = (sb.size() != 0) && evt_ready_i;
      drop = q && (sb.size() == DEPTH) && !pop;
      if (pop) void'(sb.pop_front());
      if (q && !drop) sb.push_back({addr_i, data_i, rw_n_i});
      if (overflow_clr_i) m_cnt = drop ? 8'd1 : 8'd0;
      else if (drop && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr_i) m_ovf = 1'b0;
    end
  end

  // Drive one cycle starting just after a posedge; returns 1 unit after the next one.
  task automatic cyc(input logic stb, input logic [15:0] a, input logic [7:0] d,
                     input logic rw, input logic rdy, input logic clr);
    data_in_strobe_i = stb;
    addr_i           = a;
    data_i           = d;
    rw_n_i           = rw;
    evt_ready_i      = rdy;
    overflow_clr_i   = clr;
    @(posedge clk_logic);
    #1;
    data_in_strobe_i = 1'b0;
    overflow_clr_i   = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 8'h00, 1'b1, rdy, 1'b0);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 16'hC080 + 16'(i), base + 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk_logic);
    #1;
    reset = 1'b0;
    check("rst_valid", 32'(evt_valid_o), 32'd0);
    check("rst_addr", 32'(evt_addr_o), 32'h0);
    check("rst_data", 32'(evt_data_o), 32'h0);
    check("rst_rw_n", 32'(evt_rw_n_o), 32'd1);
    check("rst_level", 32'(level_o), 32'd0);

    // Single write event, 1-cycle latency, then popped
    cyc(1'b1, 16'hC083, 8'h5A, 1'b0, 1'b0, 1'b0);
    check("t1_valid", 32'(evt_valid_o), 32'd1);
    check("t1_addr", 32'(evt_addr_o), 32'hC083);
    check("t1_data", 32'(evt_data_o), 32'h5A);
    check("t1_rw_n", 32'(evt_rw_n_o), 32'd0);
    check("t1_level", 32'(level_o), 32'd1);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0);
    check("t1_pop_valid", 32'(evt_valid_o), 32'd0);
    check("t1_pop_level", 32'(level_o), 32'd0);

    // Filtering: out-of-window write and read are ignored
    cyc(1'b1, 16'hC070, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hC085, 8'h22, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'hC08F, 8'h33, 1'b0, 1'b0, 1'b0);
    check("t2_level", 32'(level_o), 32'd1);
    check("t2_addr", 32'(evt_addr_o), 32'hC08F);
    idle(1, 1'b1);
    check("t2_empty", 32'(level_o), 32'd0);

    // Fill, overflow by 2, drain in order, clear
    fill(8'h00);
    cyc(1'b1, 16'hC080, 8'hAA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hC081, 8'hBB, 1'b0, 1'b0, 1'b0);
    check("t3_level", 32'(level_o), 32'd16);
    check("t3_ovf", 32'(overflow_o), 32'd1);
    check("t3_drops", 32'(drop_count_o), 32'd2);
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_drain_data", 32'(evt_data_o), 32'(i));
      cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0);
    end
    check("t3_drained", 32'(level_o), 32'd0);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1);
    check("t3_clr_ovf", 32'(overflow_o), 32'd0);
    check("t3_clr_cnt", 32'(drop_count_o), 32'd0);

    // Full with simultaneous pop and push: no drop
    fill(8'h10);
    cyc(1'b1, 16'hC08E, 8'h77, 1'b0, 1'b1, 1'b0);
    check("t4_level", 32'(level_o), 32'd16);
    check("t4_drops", 32'(drop_count_o), 32'd0);
    check("t4_ovf", 32'(overflow_o), 32'd0);
    idle(DEPTH, 1'b1);
    check("t4_drained", 32'(level_o), 32'd0);

    // Saturating drop counter, clear racing a drop
    fill(8'h40);
    for (int i = 0; i < 300; i++) cyc(1'b1, 16'hC082, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("t5_sat", 32'(drop_count_o), 32'hFF);
    check("t5_ovf", 32'(overflow_o), 32'd1);
    cyc(1'b1, 16'hC082, 8'hEE, 1'b0, 1'b0, 1'b1);
    check("t5_clr_drop_cnt", 32'(drop_count_o), 32'd1);
    check("t5_clr_drop_ovf", 32'(overflow_o), 32'd1);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1);
    check("t5_clr_cnt", 32'(drop_count_o), 32'd0);
    idle(11, 1'b1);
    evt_ready_i = 1'b0;
    check("t6_level5", 32'(level_o), 32'd5);

    // Reset with a strobe in the same cycle
    reset = 1'b1;
    cyc(1'b1, 16'hC084, 8'h99, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("t6_level", 32'(level_o), 32'd0);
    check("t6_valid", 32'(evt_valid_o), 32'd0);
    idle(2, 1'b0);
    check("t6_still_empty", 32'(level_o), 32'd0);

    @(negedge clk_logic);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
